// File: rtl/fifo8x8.sv
// fifo8x8: 8-bit x 8-entry first-word-fall-through FIFO with registered status flags.
// Optional sticky error output o_err is enabled by defining FIFO8X8_ERR_EN.
module fifo8x8 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_put,
  input  logic                       i_take,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_empty,
  output logic                       o_full,
`ifdef FIFO8X8_ERR_EN
  output logic                       o_err,
`endif
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wptr_r;
  logic [AW-1:0]    rptr_r;
  logic [AW:0]      count_r;
  logic [AW:0]      count_nxt_s;
  logic             empty_r;
  logic             full_r;
  logic             take_acc_s;
  logic             put_acc_s;

  // A put into a full queue is still accepted when a take frees a slot in the same cycle.
  assign take_acc_s = i_take & ~empty_r;
  assign put_acc_s  = i_put & (~full_r | take_acc_s);

  // Next element count from the accepted put/take pair.
  always_comb begin
    count_nxt_s = count_r;
    case ({put_acc_s, take_acc_s})
      2'b10:   count_nxt_s = count_r + (AW+1)'(1);
      2'b01:   count_nxt_s = count_r - (AW+1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, count and flags; pointers wrap naturally at DEPTH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else begin
      if (put_acc_s) begin
        wptr_r <= wptr_r + AW'(1);
      end
      if (take_acc_s) begin
        rptr_r <= rptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
      empty_r <= (count_nxt_s == (AW+1)'(0));
      full_r  <= (count_nxt_s == (AW+1)'(DEPTH));
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (put_acc_s) begin
      mem_r[wptr_r] <= i_data;
    end
  end

`ifdef FIFO8X8_ERR_EN
  logic err_r;

  // Sticky flag for any dropped request; only reset clears it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_r <= 1'b0;
    end else if ((i_put & ~put_acc_s) | (i_take & ~take_acc_s)) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign o_err = err_r;
`endif

  assign o_data  = mem_r[rptr_r];
  assign o_empty = empty_r;
  assign o_full  = full_r;
  assign o_count = count_r;

endmodule
